cla_pipe_adder: RTL and testbench

//   Parametrised, pipelined carry-look-ahead adder/subtractor built from

---
 rtl/cla_pipe_adder_pkg.sv | 27 ++
 rtl/cla_group.sv | 40 ++++
 rtl/cla_pipe_adder.sv | 147 ++++++++++++++
 tb/tb_cla_pipe_adder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pipe_adder_pkg.sv
// Shared constants and the carry-look-ahead helper used by the CLA group.
// The helper flattens the carry recurrence into a sum of generate/propagate products.
package cla_pipe_adder_pkg;

    localparam int MAX_BLOCK = 64;

    // Carry out of bit 'top' given per-bit propagate/generate and group carry-in
    function automatic logic la_carry(
        input logic [MAX_BLOCK-1:0] p,
        input logic [MAX_BLOCK-1:0] g,
        input logic                 c0,
        input logic [5:0]           top
    );
        logic acc;
        logic run;
        acc = g[top];
        run = p[top];
        for (int j = MAX_BLOCK - 2; j >= 0; j--) begin
            if (j < int'(top)) begin
                acc = acc | (run & g[j[5:0]]);
                run = run & p[j[5:0]];
            end
        end
        return acc | (run & c0);
    endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational BLOCK-bit carry-look-ahead group: sum, carry out, carry into
// the group's top bit, and group propagate/generate.
module cla_group
    import cla_pipe_adder_pkg::*;
#(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             c0,
    output logic [BLOCK-1:0] s,
    output logic             c_out,
    output logic             c_msb,
    output logic             p,
    output logic             g
);

    logic [BLOCK-1:0] p_s;
    logic [BLOCK-1:0] g_s;
    logic [BLOCK:0]   c_s;

    assign p_s = a ^ b;
    assign g_s = a & b;

    // Every internal carry is computed directly from c0, not rippled
    always_comb begin
        c_s    = {(BLOCK + 1){1'b0}};
        c_s[0] = c0;
        for (int i = 0; i < BLOCK; i++) begin
            c_s[i+1] = la_carry(64'(p_s), 64'(g_s), c0, 6'(i));
        end
    end

    assign s     = p_s ^ c_s[BLOCK-1:0];
    assign c_out = c_s[BLOCK];
    assign c_msb = c_s[BLOCK-1];
    assign p     = &p_s;
    assign g     = la_carry(64'(p_s), 64'(g_s), 1'b0, 6'(BLOCK - 1));

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor: one BLOCK-bit group per stage, group carry
// registered between stages, valid/ready streaming with a global advance.
module cla_pipe_adder
    import cla_pipe_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTAGE = WIDTH / BLOCK;

    if (BLOCK < 1 || BLOCK > MAX_BLOCK || BLOCK > WIDTH) begin : g_bad_block
        $error("cla_pipe_adder: BLOCK must lie in 1..min(WIDTH, MAX_BLOCK)");
    end
    if (WIDTH % BLOCK != 0) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a multiple of BLOCK");
    end

    logic             adv_s;
    logic [WIDTH-1:0] bx_s;
    logic             c0_s;

    assign adv_s    = ~out_valid | out_ready;
    assign in_ready = adv_s;
    assign bx_s     = sub ? ~b : b;
    assign c0_s     = sub ? 1'b1 : cin;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int SW = (k + 1) * BLOCK;

        logic [BLOCK-1:0] ga_s;
        logic [BLOCK-1:0] gb_s;
        logic [BLOCK-1:0] gs_s;
        logic             gc_s;
        logic             gco_s;
        logic             gcm_s;
        logic             gp_s;
        logic             gg_s;
        logic             stage_unused_s;
        logic             vld_in_s;
        logic [SW-1:0]    s_d;
        logic [SW-1:0]    s_q;
        logic             vld_q;
        logic             c_q;

        if (k == 0) begin : g_head
            assign ga_s     = a[BLOCK-1:0];
            assign gb_s     = bx_s[BLOCK-1:0];
            assign gc_s     = c0_s;
            assign vld_in_s = in_valid;
            assign s_d      = gs_s;
        end else begin : g_body
            assign ga_s     = g_stage[k-1].g_skew.a_q[BLOCK-1:0];
            assign gb_s     = g_stage[k-1].g_skew.b_q[BLOCK-1:0];
            assign gc_s     = g_stage[k-1].c_q;
            assign vld_in_s = g_stage[k-1].vld_q;
            assign s_d      = {gs_s, g_stage[k-1].s_q};
        end

        cla_group #(.BLOCK(BLOCK)) u_grp (
            .a    (ga_s),
            .b    (gb_s),
            .c0   (gc_s),
            .s    (gs_s),
            .c_out(gco_s),
            .c_msb(gcm_s),
            .p    (gp_s),
            .g    (gg_s)
        );

        assign stage_unused_s = ^{gp_s, gg_s, gcm_s};

        // Stage valid, completed low sum bits and group carry; frozen on stall
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                s_q   <= {SW{1'b0}};
                c_q   <= 1'b0;
            end else if (adv_s) begin
                vld_q <= vld_in_s;
                s_q   <= s_d;
                c_q   <= gco_s;
            end
        end

        // Skew registers shrink by one group per stage: only pending bits travel
        if (k < NSTAGE - 1) begin : g_skew
            localparam int HW = WIDTH - SW;
            logic [HW-1:0] a_d;
            logic [HW-1:0] b_d;
            logic [HW-1:0] a_q;
            logic [HW-1:0] b_q;

            if (k == 0) begin : g_src
                assign a_d = a[WIDTH-1:BLOCK];
                assign b_d = bx_s[WIDTH-1:BLOCK];
            end else begin : g_src
                assign a_d = g_stage[k-1].g_skew.a_q[HW+BLOCK-1:BLOCK];
                assign b_d = g_stage[k-1].g_skew.b_q[HW+BLOCK-1:BLOCK];
            end

            // Pending operand bits for the groups still ahead
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= {HW{1'b0}};
                    b_q <= {HW{1'b0}};
                end else if (adv_s) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        if (k == NSTAGE - 1) begin : g_tail
            logic ovf_q;

            // Signed overflow: carry into the MSB differs from carry out of it
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv_s) begin
                    ovf_q <= gco_s ^ gcm_s;
                end
            end
        end
    end

    assign out_valid = g_stage[NSTAGE-1].vld_q;
    assign sum       = g_stage[NSTAGE-1].s_q;
    assign cout      = g_stage[NSTAGE-1].c_q;
    assign ovf       = g_stage[NSTAGE-1].g_tail.ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: scoreboard of {ovf,cout,sum} results
// for a 16/4 instance, plus directed runs on 8/8 and 12/3 instances.
module tb_cla_pipe_adder;

    typedef logic [17:0] res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;

    logic        v8_in_valid, v8_in_ready, v8_cin, v8_sub, v8_out_valid, v8_out_ready, v8_cout, v8_ovf;
    logic [7:0]  v8_a, v8_b, v8_sum;

    logic        w12_in_valid, w12_in_ready, w12_cin, w12_sub, w12_out_valid, w12_out_ready, w12_cout, w12_ovf;
    logic [11:0] w12_a, w12_b, w12_sum;

    cla_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    cla_pipe_adder #(.WIDTH(8), .BLOCK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8_in_valid), .in_ready(v8_in_ready),
        .a(v8_a), .b(v8_b), .cin(v8_cin), .sub(v8_sub), .out_valid(v8_out_valid),
        .out_ready(v8_out_ready), .sum(v8_sum), .cout(v8_cout), .ovf(v8_ovf)
    );

    cla_pipe_adder #(.WIDTH(12), .BLOCK(3)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(w12_in_valid), .in_ready(w12_in_ready),
        .a(w12_a), .b(w12_b), .cin(w12_cin), .sub(w12_sub), .out_valid(w12_out_valid),
        .out_ready(w12_out_ready), .sum(w12_sum), .cout(w12_cout), .ovf(w12_ovf)
    );

    res_t sb_q[$];
    res_t w12_q[$];
    int   total = 0;
    int   bad = 0;
    int   acc_cnt = 0;
    logic popped;
    res_t last_res;
    logic held_v;
    res_t held_res;
    res_t e;
    int   lat, start_cnt, w12_first;

    // Reference: exact (w+1)-bit arithmetic, ovf from carry into MSB vs carry out
    function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic mc, input logic ms, input int w);
        logic [17:0] mask, m1, x, y, full, low;
        logic        c, co, cm;
        mask = (18'd1 << w) - 18'd1;
        m1   = mask >> 1;
        x    = {2'b00, ma} & mask;
        y    = {2'b00, (ms ? ~mb : mb)} & mask;
        c    = ms ? 1'b1 : mc;
        full = x + y + {17'd0, c};
        low  = (x & m1) + (y & m1) + {17'd0, c};
        co   = full[w[4:0]];
        cm   = low[5'(w - 1)];
        return {co ^ cm, co, full[15:0] & mask[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle on the 16/4 instance: inputs already driven just after a negedge
    task automatic step();
        res_t obs, ex;
        #1;
        obs    = {ovf, cout, sum};
        popped = 1'b0;
        if (held_v) chk("stall_hold", {13'd0, out_valid, obs}, {13'd0, 1'b1, held_res});
        if (out_valid && out_ready) begin
            popped   = 1'b1;
            last_res = obs;
            chk("out_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                ex = sb_q.pop_front();
                chk("result", {14'd0, obs}, {14'd0, ex});
            end
        end
        held_v   = out_valid && !out_ready;
        held_res = obs;
        if (in_valid && in_ready) begin
            sb_q.push_back(model(a, b, cin, sub, 16));
            acc_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic ts, input logic ordy);
        in_valid  = v;
        a         = ta;
        b         = tb;
        cin       = tc;
        sub       = ts;
        out_ready = ordy;
        step();
    endtask

    task automatic single(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tc, input logic ts, input res_t exp);
        int l;
        l = 0;
        drive(1'b1, ta, tb, tc, ts, 1'b1);
        for (int n = 1; n <= 10; n++) begin
            drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
            if (popped) begin
                l = n;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(l), 32'd4);
        chk({tag, "_value"}, {14'd0, last_res}, {14'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        v8_in_valid = 1'b0; v8_a = 8'h0; v8_b = 8'h0; v8_cin = 1'b0; v8_sub = 1'b0; v8_out_ready = 1'b1;
        w12_in_valid = 1'b0; w12_a = 12'h0; w12_b = 12'h0; w12_cin = 1'b0; w12_sub = 1'b0; w12_out_ready = 1'b1;
        held_v = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_v8_out_valid", 32'(v8_out_valid), 32'd0);
        chk("rst_w12_out_valid", 32'(w12_out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        single("t1_ffff_plus_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
        single("t2_7fff_plus_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
        single("t2_5_minus_7", 16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        single("t2_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, {1'b0, 1'b0, 16'h5556});
        single("t2_sub_ignores_cin", 16'h8000, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b1, 16'h7FFF});

        // Random traffic with random backpressure
        start_cnt = acc_cnt;
        for (int cyc = 0; cyc < 3000 && (acc_cnt - start_cnt) < 100; cyc++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        chk("t3_beats_accepted", 32'(acc_cnt - start_cnt), 32'd100);
        for (int n = 0; n < 50 && sb_q.size() != 0; n++) begin
            drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        end
        chk("t3_drained", 32'(sb_q.size()), 32'd0);

        // Fill the pipe against a stalled sink, hold, then release
        start_cnt = acc_cnt;
        for (int n = 0; n < 6; n++) begin
            drive(1'b1, 16'(16'h1111 * n), 16'(16'h0F0F + n), 1'b0, 1'b0, 1'b0);
        end
        chk("t4_fill_count", 32'(acc_cnt - start_cnt), 32'd4);
        for (int n = 0; n < 5; n++) begin
            drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
            chk("t4_in_ready_low", 32'(in_ready), 32'd0);
            chk("t4_out_valid_held", 32'(out_valid), 32'd1);
        end
        for (int n = 0; n < 4; n++) begin
            drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
            chk("t4_one_per_cycle", 32'(popped), 32'd1);
        end
        chk("t4_drained", 32'(sb_q.size()), 32'd0);

        // Reset with three beats in flight
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 16'(16'h0101 << n), 16'h00FF, 1'b0, 1'b0, 1'b1);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_sum", 32'(sum), 32'd0);
        chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
        sb_q.delete();
        held_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
            chk("t5_no_stale", 32'(out_valid), 32'd0);
        end
        single("t5_after_reset", 16'h00F0, 16'h0F10, 1'b0, 1'b0, {1'b0, 1'b0, 16'h1000});

        // Single-stage instance
        v8_a = 8'h80; v8_b = 8'h80; v8_cin = 1'b0; v8_sub = 1'b0; v8_in_valid = 1'b1;
        #1;
        chk("v8_out_valid_before", 32'(v8_out_valid), 32'd0);
        @(negedge clk);
        v8_a = 8'h00; v8_b = 8'h01; v8_sub = 1'b1;
        #1;
        chk("v8_latency", 32'(v8_out_valid), 32'd1);
        chk("v8_80_plus_80", {14'd0, v8_ovf, v8_cout, 8'h00, v8_sum}, {14'd0, 1'b1, 1'b1, 16'h0000});
        @(negedge clk);
        v8_in_valid = 1'b0;
        #1;
        e = model({8'h00, 8'h00}, {8'h00, 8'h01}, 1'b0, 1'b1, 8);
        chk("v8_0_minus_1", {14'd0, v8_ovf, v8_cout, 8'h00, v8_sum}, {14'd0, e});
        @(negedge clk);

        // Four-stage 12/3 instance: full propagate chains with every low 6-bit pattern
        w12_first = -1;
        for (int i = 0; i < 264; i++) begin
            if (i < 256) begin
                w12_in_valid = 1'b1;
                w12_a   = {6'h3F, i[5:0]};
                w12_b   = {6'h00, ~i[5:0]};
                w12_cin = i[6];
                w12_sub = i[7];
            end else begin
                w12_in_valid = 1'b0;
            end
            #1;
            if (w12_out_valid) begin
                if (w12_first < 0) begin
                    w12_first = i;
                    chk("w12_latency", 32'(i), 32'd4);
                end
                chk("w12_out_expected", 32'(w12_q.size() != 0), 32'd1);
                if (w12_q.size() != 0) begin
                    e = w12_q.pop_front();
                    chk("w12_result", {14'd0, w12_ovf, w12_cout, 4'h0, w12_sum}, {14'd0, e});
                end
            end
            if (w12_in_valid && w12_in_ready) begin
                w12_q.push_back(model({4'h0, w12_a}, {4'h0, w12_b}, w12_cin, w12_sub, 12));
            end
            @(negedge clk);
        end
        chk("w12_saw_output", 32'(w12_first >= 0), 32'd1);
        chk("w12_drained", 32'(w12_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
